inst_fetch: RTL and testbench

- Front-end stage directly upstream of the instruction parser.
- Generates instruction addresses, reads 32-bit words from the instruction BRAM (fixed read latency) and buffers the returned words with their PCs.
- Presents {pc_out, instruction, valid_out} to the parser using the parser's stall semantics.
- Supports program start, redirect (loop-back from the executor) and halt (end of program).

---
 rtl/proctypes.sv | 9 +
 rtl/fetch_fifo.sv | 38 +++
 rtl/inst_fetch.sv | 86 ++++++++
 tb/tb_inst_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/proctypes.sv
// proctypes: processor-wide types shared by the front end and the BRAM wrapper.
package proctypes;
   localparam int INST_BRAM_LATENCY = 2;
   typedef logic [9:0] InstructionAddr;
   typedef enum logic {FS_IDLE, FS_RUN} FetchState;
   function automatic InstructionAddr pc_inc(input InstructionAddr pc, input int depth);
      return (int'(pc) == depth - 1) ? '0 : pc + 1'b1;
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and combinational head.
module fetch_fifo #(
   parameter int W = 32,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic [W-1:0]  head
);
   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] rd, wr;
   logic do_push, do_pop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign do_pop = pop && count != '0;
   assign do_push = push && (count != CW'(DEPTH) || do_pop);
   assign head = mem[rd];
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
   always_ff @(posedge clk)
      if (rst || flush) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= inc(wr);
         if (do_pop) rd <= inc(rd);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: issues BRAM reads, tracks them through the read latency and
// buffers returned words with their PCs for the parser.
module inst_fetch
   import proctypes::*;
#(
   parameter int BRAM_LATENCY = INST_BRAM_LATENCY,
   parameter int INST_DEPTH = 1024,
   parameter int FIFO_DEPTH = BRAM_LATENCY + 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  InstructionAddr                start_pc,
   input  logic                          redirect,
   input  InstructionAddr                redirect_pc,
   input  logic                          halt,
   input  logic                          stall,
   output logic [$clog2(INST_DEPTH)-1:0] bram_addr,
   output logic                          bram_en,
   input  logic [31:0]                   bram_dout,
   output logic                          valid_out,
   output logic [31:0]                   instruction,
   output InstructionAddr                pc_out,
   output logic                          running
);
   localparam int AW = $bits(InstructionAddr);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + BRAM_LATENCY + 2);
   FetchState state, state_n;
   InstructionAddr pc, pc_n;
   logic [BRAM_LATENCY-1:0] fl_v;
   InstructionAddr fl_pc [BRAM_LATENCY];
   logic [CW-1:0] count;
   logic [AW+31:0] head;
   logic [OW-1:0] occ;
   logic flush, pop, issue;
   assign flush = halt || (state == FS_RUN && redirect);
   assign pop = valid_out && !stall;
   assign occ = OW'(count) + OW'($countones(fl_v));
   // a pop this cycle frees the slot that the new read will eventually fill
   assign issue = state == FS_RUN && occ < OW'(FIFO_DEPTH) + OW'(pop);
   assign bram_en = issue;
   assign bram_addr = issue ? pc : '0;
   assign running = state == FS_RUN;
   assign valid_out = count != '0;
   assign instruction = valid_out ? head[AW+:32] : '0;
   assign pc_out = valid_out ? head[AW-1:0] : '0;
   always_ff @(posedge clk)
      if (rst) begin
         state <= FS_IDLE;
         pc <= '0;
      end else begin
         state <= state_n;
         pc <= pc_n;
      end
   always_comb begin
      state_n = state;
      pc_n = pc;
      if (halt) state_n = FS_IDLE;
      else if (state == FS_RUN && redirect) pc_n = redirect_pc;
      else if (state == FS_IDLE && start) begin
         state_n = FS_RUN;
         pc_n = start_pc;
      end else if (issue) pc_n = pc_inc(pc, INST_DEPTH);
   end
   // squashed reads lose their valid bit here, so they never reach the FIFO
   always_ff @(posedge clk) begin
      fl_v[0] <= issue && !(rst || flush);
      fl_pc[0] <= pc;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
         fl_v[i] <= fl_v[i-1] && !(rst || flush);
         fl_pc[i] <= fl_pc[i-1];
      end
   end
   fetch_fifo #(.W(AW + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(fl_v[BRAM_LATENCY-1]),
      .din({bram_dout, fl_pc[BRAM_LATENCY-1]}),
      .pop(pop),
      .flush(flush),
      .count(count),
      .head(head)
   );
   occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= OW'(FIFO_DEPTH));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed tables and sequences plus random traffic checked
// against a stream-level model of the fetch unit.
module tb_inst_fetch;
   import proctypes::*;
   localparam int FD = 4;
   logic clk = 1'b0;
   logic rst, start, redirect, halt, stall, bram_en, valid_out, running;
   InstructionAddr start_pc, redirect_pc, pc_out;
   logic [9:0] bram_addr;
   logic [31:0] bram_dout, instruction;
   always #5 clk = ~clk;
   inst_fetch dut (
      .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .stall(stall),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
      .valid_out(valid_out), .instruction(instruction), .pc_out(pc_out), .running(running)
   );
   function automatic logic [31:0] word(input InstructionAddr a);
      return 32'hA000_0000 + 32'(a);
   endfunction
   function automatic InstructionAddr nxt(input InstructionAddr a);
      return InstructionAddr'((int'(a) + 1) % 1024);
   endfunction
   // BRAM with two-cycle read latency; garbage when no read is returning
   logic r1_v = 1'b0, r2_v = 1'b0;
   InstructionAddr r1_a, r2_a;
   always @(posedge clk) begin
      r1_v <= bram_en;
      r1_a <= bram_addr;
      r2_v <= r1_v;
      r2_a <= r1_a;
   end
   assign bram_dout = r2_v ? word(r2_a) : 32'hDEAD_BEEF;
   int n_chk = 0, n_fail = 0;
   bit run_m, hold;
   InstructionAddr exp_pc, iss_pc, hold_pc;
   logic [31:0] hold_ins;
   int outst;
   bit s_valid, s_en, s_run;
   InstructionAddr s_pc;
   logic [31:0] s_ins;
   logic [9:0] s_addr;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic cyc(input bit rs, input bit st, input InstructionAddr sp, input bit rd,
                      input InstructionAddr rp, input bit hl, input bit sl);
      bit pop;
      rst = rs; start = st; start_pc = sp; redirect = rd; redirect_pc = rp; halt = hl; stall = sl;
      @(negedge clk);
      s_valid = valid_out; s_en = bram_en; s_run = running;
      s_pc = pc_out; s_ins = instruction; s_addr = bram_addr;
      pop = s_valid && !sl;
      if (!rs) begin
         chk("running", 32'(s_run), 32'(run_m));
         if (hold) begin
            chk("hold_valid", 32'(s_valid), 32'd1);
            chk("hold_pc", 32'(s_pc), 32'(hold_pc));
            chk("hold_ins", s_ins, hold_ins);
         end
         if (s_valid) begin
            chk("pc_out", 32'(s_pc), 32'(exp_pc));
            chk("instruction", s_ins, word(s_pc));
         end
         chk("bram_en", 32'(s_en), 32'(run_m && outst < FD + int'(pop)));
         if (s_en) chk("bram_addr", 32'(s_addr), 32'(iss_pc));
         if (!run_m) chk("idle_valid", 32'(s_valid), 32'd0);
      end
      if (rs) begin
         run_m = 0; outst = 0; hold = 0;
      end else begin
         if (pop) begin exp_pc = nxt(exp_pc); outst--; end
         if (s_en) begin iss_pc = nxt(iss_pc); outst++; end
         hold = s_valid && sl; hold_pc = s_pc; hold_ins = s_ins;
         if (hl) begin
            run_m = 0; outst = 0; hold = 0;
         end else if (rd && run_m) begin
            exp_pc = rp; iss_pc = rp; outst = 0; hold = 0;
         end else if (st && !run_m) begin
            run_m = 1; exp_pc = sp; iss_pc = sp; outst = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n, input bit sl);
      repeat (n) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, sl);
   endtask
   task automatic go(input InstructionAddr sp);
      cyc(1'b0, 1'b1, sp, 1'b0, '0, 1'b0, 1'b0);
   endtask
   task automatic stop();
      cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
   endtask
   task automatic first_valid(input string nm, input InstructionAddr want);
      int k = 0;
      do begin idle(1, 1'b0); k++; end while (!s_valid && k < 12);
      chk({nm, "_latency"}, 32'(k - 1), 32'd3);
      chk({nm, "_first_pc"}, 32'(s_pc), 32'(want));
   endtask
   task automatic run_to(input InstructionAddr p);
      int k = 0;
      while (!(s_valid && s_pc == p) && k < 60) begin idle(1, 1'b0); k++; end
      chk("reach_pc", 32'(s_pc), 32'(p));
   endtask
   task automatic zeros(input string nm);
      chk({nm, "_valid"}, 32'(s_valid), 32'd0);
      chk({nm, "_ins"}, s_ins, 32'd0);
      chk({nm, "_pc"}, 32'(s_pc), 32'd0);
      chk({nm, "_en"}, 32'(s_en), 32'd0);
      chk({nm, "_addr"}, 32'(s_addr), 32'd0);
      chk({nm, "_run"}, 32'(s_run), 32'd0);
   endtask
   typedef struct {
      InstructionAddr spc;
      InstructionAddr first;
      InstructionAddr fourth;
   } vec_t;
   vec_t tbl [4];
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{spc: 10'd0,    first: 10'd0,    fourth: 10'd3};
      tbl[1] = '{spc: 10'd1022, first: 10'd1022, fourth: 10'd1};
      tbl[2] = '{spc: 10'd20,   first: 10'd20,   fourth: 10'd23};
      tbl[3] = '{spc: 10'd1023, first: 10'd1023, fourth: 10'd2};
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      idle(1, 1'b0);
      zeros("reset");
      foreach (tbl[i]) begin
         stop();
         go(tbl[i].spc);
         first_valid("table", tbl[i].first);
         for (int j = 0; j < 3; j++) begin
            idle(1, 1'b0);
            chk("table_stream_valid", 32'(s_valid), 32'd1);
         end
         chk("table_fourth_pc", 32'(s_pc), 32'(tbl[i].fourth));
      end
      // stall while pc 7 is presented
      stop();
      go(10'd0);
      run_to(10'd6);
      for (int j = 0; j < 5; j++) begin
         idle(1, 1'b1);
         chk("stall_pc", 32'(s_pc), 32'd7);
      end
      chk("stall_full_en", 32'(s_en), 32'd0);
      idle(1, 1'b0);
      chk("release_pc7", 32'(s_pc), 32'd7);
      idle(1, 1'b0);
      chk("release_pc8", 32'(s_pc), 32'd8);
      // redirect while pc 12 is presented
      run_to(10'd11);
      cyc(1'b0, 1'b0, '0, 1'b1, 10'd3, 1'b0, 1'b0);
      chk("redirect_at", 32'(s_pc), 32'd12);
      first_valid("redirect", 10'd3);
      idle(6, 1'b0);
      // halt then restart
      stop();
      idle(1, 1'b0);
      chk("halt_valid", 32'(s_valid), 32'd0);
      chk("halt_run", 32'(s_run), 32'd0);
      chk("halt_en", 32'(s_en), 32'd0);
      idle(3, 1'b0);
      go(10'd20);
      first_valid("restart", 10'd20);
      // reset with a full buffer and a read in flight
      idle(6, 1'b1);
      idle(1, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      for (int j = 0; j < 5; j++) begin
         idle(1, 1'b0);
         zeros("midreset");
      end
      // halt outranks redirect and start
      go(10'd5);
      idle(6, 1'b0);
      cyc(1'b0, 1'b1, 10'd9, 1'b1, 10'd7, 1'b1, 1'b0);
      idle(1, 1'b0);
      chk("coinc_run", 32'(s_run), 32'd0);
      chk("coinc_valid", 32'(s_valid), 32'd0);
      chk("coinc_en", 32'(s_en), 32'd0);
      idle(3, 1'b0);
      for (int j = 0; j < 1500; j++)
         cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, InstructionAddr'($urandom_range(0, 1023)),
             $urandom_range(0, 39) == 0, InstructionAddr'($urandom_range(0, 1023)),
             $urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
